// File: rtl/bch_pkg.sv
// -----------------------------------------------------------------------------
// bch_pkg
// Shared constants, types and helpers for the (21,16) BCH/Hamming code.
//   Codeword layout (bit index -> content), Hamming position = index + 1:
//     0=p1, 1=p2, 2=d0, 3=p3, 4..6=d1..d3, 7=p4, 8..14=d4..d10,
//     15=p5, 16..20=d11..d15
// -----------------------------------------------------------------------------
package bch_pkg;

  localparam int N       = 21;  // codeword length
  localparam int K       = 16;  // data bits
  localparam int R       = 5;   // parity / syndrome bits
  localparam int MAX_POS = 21;  // highest valid Hamming position

  typedef logic [N-1:0] codeword_t;
  typedef logic [K-1:0] dataword_t;
  typedef logic [R-1:0] syndrome_t;

  // Pull the 16 data bits out of their non-power-of-two positions.
  function automatic dataword_t extract_data(input codeword_t cw);
    return {cw[20:16], cw[14:8], cw[6:4], cw[2]};
  endfunction

endpackage

// File: rtl/bch_syndrome.sv
// -----------------------------------------------------------------------------
// bch_syndrome
// Purely combinational syndrome generator for the (21,16) code.
//   code_i     : received codeword (bit 0 = Hamming position 1)
//   syndrome_o : binary position of a single-bit error, 0 when clean
// -----------------------------------------------------------------------------
module bch_syndrome
  import bch_pkg::*;
(
  input  codeword_t code_i,
  output syndrome_t syndrome_o
);

  // XOR-ing the positions of all set bits is the same as computing every
  // s[k] as the parity of the bits whose position has bit k set.
  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    syndrome_o = '0;
    for (int i = 0; i < N; i++) begin
      if (code_i[i]) syndrome_o = syndrome_o ^ syndrome_t'(i + 1);
    end
  end

endmodule

// File: rtl/bch_decoder.sv
// -----------------------------------------------------------------------------
// bch_decoder
// Two-stage elastic decoder for (21,16) BCH/Hamming codewords: single-error
// correction, uncorrectable-syndrome flagging and saturating error counters.
//   clk, reset           : clock, synchronous active-high reset
//   code_in/valid_in     : input codeword and its valid
//   ready_in             : decoder accepts code_in this cycle
//   data_out/valid_out   : corrected data word and its valid
//   ready_out            : downstream accepts data_out
//   err_corrected        : single error corrected (data or parity bit)
//   err_uncorrectable    : syndrome 22..31, data_out is raw extracted data
//   clr_counts           : synchronous clear of both counters (wins over inc)
//   corrected_count      : saturating count of words decoded with err_corrected
//   uncorrectable_count  : saturating count of words decoded as uncorrectable
// -----------------------------------------------------------------------------
module bch_decoder
  import bch_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     code_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [K-1:0]     data_out,
  output logic             valid_out,
  input  logic             ready_out,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  input  logic             clr_counts,
  output logic [CNT_W-1:0] corrected_count,
  output logic [CNT_W-1:0] uncorrectable_count
);

  // Stage 1: raw codeword plus its syndrome
  logic      s1_valid_q;
  codeword_t s1_code_q;
  syndrome_t s1_syn_q;
  syndrome_t syn_in;

  // Stage 2: decoded word presented at the output
  logic      s2_valid_q;
  dataword_t s2_data_q;
  logic      s2_corr_q;
  logic      s2_unc_q;

  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;
  logic [CNT_W-1:0] unc_cnt_q,  unc_cnt_d;

  logic      s1_advance;
  logic      s1_accept;
  logic      s2_load;
  codeword_t fixed_code;
  logic      corr_d;
  logic      unc_d;

  bch_syndrome u_syndrome (
    .code_i     (code_in),
    .syndrome_o (syn_in)
  );

  // Elastic handshake: S2 can take a new word when empty or draining this
  // cycle; S1 can take one when empty or when it hands its word to S2.
  assign s1_advance = !s2_valid_q || ready_out;
  assign ready_in   = !s1_valid_q || s1_advance;
  assign s1_accept  = valid_in && ready_in;
  assign s2_load    = s1_advance && s1_valid_q;

  // Correction: flip the bit at the syndrome position when it names a real
  // bit; syndromes beyond the codeword length cannot be single errors.
  always_comb begin
    fixed_code = s1_code_q;
    corr_d     = 1'b0;
    unc_d      = 1'b0;
    if (s1_syn_q != '0) begin
      if (s1_syn_q <= syndrome_t'(MAX_POS)) begin
        corr_d = 1'b1;
        for (int i = 0; i < N; i++) begin
          if (s1_syn_q == syndrome_t'(i + 1)) fixed_code[i] = ~s1_code_q[i];
        end
      end else begin
        unc_d = 1'b1;
      end
    end
  end

  // Counters follow words entering S2, not words leaving it.
  always_comb begin
    corr_cnt_d = corr_cnt_q;
    unc_cnt_d  = unc_cnt_q;
    if (clr_counts) begin
      corr_cnt_d = '0;
      unc_cnt_d  = '0;
    end else if (s2_load) begin
      if (corr_d && !(&corr_cnt_q)) corr_cnt_d = corr_cnt_q + CNT_W'(1);
      if (unc_d  && !(&unc_cnt_q))  unc_cnt_d  = unc_cnt_q  + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_code_q  <= '0;
      s1_syn_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_corr_q  <= 1'b0;
      s2_unc_q   <= 1'b0;
      corr_cnt_q <= '0;
      unc_cnt_q  <= '0;
    end else begin
      if (ready_in) s1_valid_q <= valid_in;
      if (s1_accept) begin
        s1_code_q <= code_in;
        s1_syn_q  <= syn_in;
      end
      if (s1_advance) s2_valid_q <= s1_valid_q;
      // Data and flags only move on a real load, so they hold while stalled.
      if (s2_load) begin
        s2_data_q <= extract_data(fixed_code);
        s2_corr_q <= corr_d;
        s2_unc_q  <= unc_d;
      end
      corr_cnt_q <= corr_cnt_d;
      unc_cnt_q  <= unc_cnt_d;
    end
  end

  assign data_out            = s2_data_q;
  assign valid_out           = s2_valid_q;
  assign err_corrected       = s2_corr_q;
  assign err_uncorrectable   = s2_unc_q;
  assign corrected_count     = corr_cnt_q;
  assign uncorrectable_count = unc_cnt_q;

endmodule

// File: doc/bch_decoder.md
Name: bch_decoder

Overview:
- Receive-side counterpart of the (21,16) BCH/Hamming encoder. Takes 21-bit codewords, computes a 5-bit syndrome, corrects any single-bit error and extracts the 16 data bits.
- Flags uncorrectable syndromes and keeps saturating error statistics.
- Two-stage pipeline with valid/ready handshakes on both sides. Sits between the channel/deserializer and the payload consumer.

Parameters:
- CNT_W, 16, width of each saturating error counter (min 2)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- code_in  in  21  received codeword, bit 0 = Hamming position 1
- valid_in  in  1  code_in valid this cycle
- ready_in  out  1  decoder accepts code_in this cycle
- data_out  out  16  corrected data word
- valid_out  out  1  data_out and flags valid
- ready_out  in  1  downstream accepts data_out
- err_corrected  out  1  single error corrected in this word (data or parity bit)
- err_uncorrectable  out  1  syndrome 22..31; data_out is raw extracted, uncorrected
- clr_counts  in  1  synchronous clear of both counters
- corrected_count  out  CNT_W  words with err_corrected, saturating
- uncorrectable_count  out  CNT_W  words with err_uncorrectable, saturating

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset). When reset is high at a clk edge, every output and all pipeline state clear on that edge: valid_out=0, data_out=0, both flags=0, both counters=0.
  - In-flight words are discarded. No partial word may appear after reset deasserts.
  - ready_in=1 in the first cycle after reset.
- Codeword layout (bit index -> content):
  - 0=p1, 1=p2, 2=d0, 3=p3, 4..6=d1..d3, 7=p4, 8..14=d4..d10, 15=p5, 16..20=d11..d15.
  - Hamming position = bit index + 1.
- Syndrome: s[k] = XOR of code_in bits whose position has bit k set, for k=0..4. s is the binary position of a single error.
- Stage 1 (S1), on an accepted input (valid_in && ready_in): register code_in and the syndrome; set s1_valid.
- Stage 2 (S2), on advance from S1:
  - s==0: no correction, both flags 0.
  - 1<=s<=21: flip bit s-1, err_corrected=1. This includes parity-bit positions 1,2,4,8,16, where data is unchanged but the flag is still set.
  - s>=22: no flip, err_uncorrectable=1.
  - Extract data per the layout; register data_out and the flags; set valid_out.
- Latency: 2 cycles from acceptance to valid_out with no stall. Throughput is 1 word/cycle.
- Handshake: standard elastic pipeline.
  - ready_in = !s1_valid || s1_advance.
  - s1_advance = !valid_out || ready_out.
  - Output transfer occurs when valid_out && ready_out.
  - While valid_out && !ready_out, data_out, the flags and valid_out hold stable.
  - No bubble insertion and no word loss or duplication under any ready_out pattern.
- Counters:
  - Increment on the cycle a word is loaded into S2 with the respective flag set. They count words decoded, not words transferred.
  - They saturate at 2^CNT_W-1.
  - clr_counts has priority over a simultaneous increment: result is 0.
- Known limitation: there is no overall parity. A double error either gives s in 1..21 and miscorrects, or gives s>=22 and is detected. This is not a bug.
- valid_in while ready_in=0: code_in is ignored. The upstream must hold it.

Decomposition:
- bch_pkg:
  - Constants N=21, K=16, R=5.
  - Typedefs codeword_t (logic[20:0]), dataword_t (logic[15:0]), syndrome_t (logic[4:0]).
  - Function extract_data(codeword_t) returning dataword_t per the layout.
  - Constant MAX_POS=21.
- Sub-module bch_syndrome: combinational codeword_t -> syndrome_t, reusable by a future checker.

Test Plan:
- Clean words: send 21'h000007, 21'h108009, 21'h1FFFFE, 21'h000000 with ready_out=1. Expect data_out 16'h0001, 16'h8000, 16'hFFFF, 16'h0000 exactly 2 cycles after each accept, back-to-back, with flags 0 and counters 0.
- Single errors:
  - 21'h000003 (d0 flipped from 0x000007) -> 16'h0001, err_corrected=1.
  - 21'h000006 (p1 flipped) -> 16'h0001, err_corrected=1.
  - 21'h008009 (bit 20 flipped from 0x108009) -> 16'h8000.
  - Expect corrected_count=3.
  - Sweep all 21 single-bit flips of 0x1FFFFE -> always 16'hFFFF.
- Uncorrectable: 21'h008080 (positions 8 and 16 flipped from 0) -> s=24, err_uncorrectable=1, data_out=16'h0000, uncorrectable_count=1. 21'h000003 from codeword 0 (positions 1 and 2 flipped) -> miscorrected 16'h0001 with err_corrected=1, the documented limitation.
- Backpressure: stream 8 words with random ready_out at roughly 50%. Expect an in-order, loss-free, duplicate-free output sequence. data_out must hold while stalled. ready_in=0 only when both stages are full and ready_out=0.
- Reset mid-operation: assert reset with both stages full and ready_out=0. Next cycle expect valid_out=0, counters=0, ready_in=1. A new word 21'h108009 must emerge 2 cycles after acceptance, with no stale word before it.
- Counter saturation/clear: with CNT_W=2, send 5 corrected words -> corrected_count=3. Assert clr_counts in the same cycle as a corrected word loads into S2 -> corrected_count=0.
